// File: rtl/divider_pkg.sv
`default_nettype none
// ============================================================================
// Module      : divider_pkg
// Description : Shared FSM encoding and conditional-negate helpers for the
//               sequential restoring divider.
// Revision    : 1.0 - initial release
// ============================================================================
package divider_pkg;

    localparam int ST_W  = 2;
    // Helpers work on a wide container; callers zero-extend and truncate.
    localparam int MAX_W = 64;

    typedef enum logic [ST_W-1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] v);
        return -v;
    endfunction

    // Absolute value when en is the operand's sign bit; sign fix-up otherwise.
    function automatic logic [MAX_W-1:0] cond_neg(input logic [MAX_W-1:0] v,
                                                   input logic             en);
        return en ? negate(v) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/divider_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq_if
// Description : go/done host interface of the sequential divider.
// Revision    : 1.0 - initial release
// ============================================================================
interface divider_seq_if #(
    parameter int WIDTH = 8
);
    import divider_pkg::*;

    logic             go;
    logic             sgn;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             error;
    logic             busy;
    logic             done;
    logic [ST_W-1:0]  cs;

    modport master (
        output go, sgn, dividend, divisor,
        input  quotient, remainder, error, busy, done, cs
    );

    modport slave (
        input  go, sgn, dividend, divisor,
        output quotient, remainder, error, busy, done, cs
    );

endinterface
`default_nettype wire

// File: rtl/divider_seq_datapath.sv
`default_nettype none
// ============================================================================
// Module      : div_datapath
// Description : X/R/Y registers, iteration counter, WIDTH+1 bit subtractor and
//               sign fix-up. Signed support built only with
//               DIVIDER_SEQ_SIGNED_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module div_datapath
    import divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_calc,
    input  logic             i_sub_en,
    input  logic             i_sgn,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_div_zero,
    output logic             o_count_zero,
    output logic             o_r_ge_y,
    output logic             o_err,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder
);

    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_y;
    logic [CNT_W-1:0] r_count;
    logic             r_div0;

    logic [WIDTH:0]   w_rsh;
    logic [WIDTH:0]   w_t;
    logic [CNT_W-1:0] w_count_nxt;
    logic [WIDTH-1:0] w_x_abs;
    logic [WIDTH-1:0] w_y_abs;
    logic [WIDTH-1:0] w_x_load;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

`ifdef DIVIDER_SEQ_SIGNED_EN
    logic w_dvd_neg;
    logic w_dvs_neg;
    logic r_neg_q;
    logic r_neg_r;

    assign w_dvd_neg = i_sgn & i_dividend[WIDTH-1];
    assign w_dvs_neg = i_sgn & i_divisor[WIDTH-1];
    // |MIN| = 2^(WIDTH-1) still fits because magnitudes are unsigned.
    assign w_x_abs   = WIDTH'(cond_neg(MAX_W'(i_dividend), w_dvd_neg));
    assign w_y_abs   = WIDTH'(cond_neg(MAX_W'(i_divisor), w_dvs_neg));
    assign w_q_fix   = WIDTH'(cond_neg(MAX_W'(r_x), r_neg_q));
    assign w_r_fix   = WIDTH'(cond_neg(MAX_W'(r_r), r_neg_r));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_load) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    logic w_unused_sgn;

    assign w_unused_sgn = i_sgn;
    assign w_x_abs      = i_dividend;
    assign w_y_abs      = i_divisor;
    assign w_q_fix      = r_x;
    assign w_r_fix      = r_r;
`endif

    assign o_div_zero   = (i_divisor == '0);
    assign w_rsh        = {r_r, r_x[WIDTH-1]};
    assign w_t          = w_rsh - {1'b0, r_y};
    assign o_r_ge_y     = ~w_t[WIDTH];
    assign w_count_nxt  = r_count - CNT_W'(1);
    assign o_count_zero = (w_count_nxt == '0);
    assign o_err        = r_div0;

    // Divide-by-zero keeps the raw dividend in X so it can be returned as-is.
    assign w_x_load     = o_div_zero ? i_dividend : w_x_abs;

    assign o_quotient   = r_div0 ? {WIDTH{1'b1}} : w_q_fix;
    assign o_remainder  = r_div0 ? r_x           : w_r_fix;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_r     <= '0;
            r_y     <= '0;
            r_count <= '0;
            r_div0  <= 1'b0;
        end else if (i_load) begin
            r_x     <= w_x_load;
            r_y     <= w_y_abs;
            r_r     <= '0;
            r_count <= CNT_W'(WIDTH);
            r_div0  <= o_div_zero;
        end else if (i_calc) begin
            r_r     <= i_sub_en ? w_t[WIDTH-1:0] : w_rsh[WIDTH-1:0];
            r_x     <= {r_x[WIDTH-2:0], i_sub_en};
            r_count <= w_count_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : divider_seq
// Description : Sequential restoring divider, one quotient bit per clock,
//               go/done handshake. Signed mode: DIVIDER_SEQ_SIGNED_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module divider_seq
    import divider_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    divider_seq_if.slave  bus
);

    state_t           r_cs;
    state_t           w_ns;
    logic             w_load;
    logic             w_calc;
    logic             w_commit;
    logic             w_sub_en;
    logic             w_div_zero;
    logic             w_count_zero;
    logic             w_r_ge_y;
    logic             w_err;
    logic [WIDTH-1:0] w_q_fix;
    logic [WIDTH-1:0] w_r_fix;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_error;
    logic             r_done;

    div_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk          (clk),
        .rst          (rst),
        .i_load       (w_load),
        .i_calc       (w_calc),
        .i_sub_en     (w_sub_en),
        .i_sgn        (bus.sgn),
        .i_dividend   (bus.dividend),
        .i_divisor    (bus.divisor),
        .o_div_zero   (w_div_zero),
        .o_count_zero (w_count_zero),
        .o_r_ge_y     (w_r_ge_y),
        .o_err        (w_err),
        .o_quotient   (w_q_fix),
        .o_remainder  (w_r_fix)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs <= IDLE;
        end else begin
            r_cs <= w_ns;
        end
    end

    always_comb begin
        w_ns     = r_cs;
        w_load   = 1'b0;
        w_calc   = 1'b0;
        w_commit = 1'b0;
        w_sub_en = 1'b0;
        case (r_cs)
            IDLE: begin
                if (bus.go) begin
                    w_load = 1'b1;
                    w_ns   = w_div_zero ? DONE : CALC;
                end
            end
            CALC: begin
                w_calc   = 1'b1;
                w_sub_en = w_r_ge_y;
                if (w_count_zero) begin
                    w_ns = DONE;
                end
            end
            DONE: begin
                w_commit = 1'b1;
                w_ns     = IDLE;
            end
            default: begin
                w_ns = IDLE;
            end
        endcase
    end

    // Results only move on commit, so they stay stable through CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_quotient  <= '0;
            r_remainder <= '0;
            r_error     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_quotient  <= w_q_fix;
                r_remainder <= w_r_fix;
                r_error     <= w_err;
            end
        end
    end

    assign bus.quotient  = r_quotient;
    assign bus.remainder = r_remainder;
    assign bus.error     = r_error;
    assign bus.done      = r_done;
    assign bus.busy      = (r_cs == CALC) || (r_cs == DONE);
    assign bus.cs        = r_cs;

endmodule
`default_nettype wire

// File: tb/tb_divider_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_divider_seq
// Description : Self-checking bench for divider_seq (WIDTH 8, plus 4 and 16).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_divider_seq;
    import divider_pkg::*;

`ifdef DIVIDER_SEQ_SIGNED_EN
    localparam bit SIGNED_EN = 1'b1;
`else
    localparam bit SIGNED_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        int         lat;
        int         go_cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    divider_seq_if #(.WIDTH(8))  b8  ();
    divider_seq_if #(.WIDTH(4))  b4  ();
    divider_seq_if #(.WIDTH(16)) b16 ();

    divider_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));
    divider_seq #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(b4));
    divider_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(b16));

    exp_t sb[$];
    int   n_chk    = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   busy_cnt = 0;
    int   done_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t mk(input logic [7:0] q, input logic [7:0] r, input logic err);
        exp_t e;
        e.q = q; e.r = r; e.e = err;
        e.lat = err ? 1 : 9;
        e.go_cyc = 0;
        return e;
    endfunction

    // Reference: native int division truncates toward zero, as required.
    function automatic exp_t model(input logic s, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sd, q, r;
        e = mk(8'h00, 8'h00, 1'b0);
        if (b == 8'h00) begin
            e = mk(8'hFF, a, 1'b1);
        end else if (s && SIGNED_EN) begin
            sa = int'($signed(a));
            sd = int'($signed(b));
            q  = sa / sd;
            r  = sa % sd;
            e.q = q[7:0];
            e.r = r[7:0];
        end else begin
            e.q = a / b;
            e.r = a % b;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (b8.busy) busy_cnt++;
        if (b8.done) begin
            done_cnt++;
            chk("done_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("quotient",  b8.quotient,  e.q);
                chk("remainder", b8.remainder, e.r);
                chk("error",     b8.error,     e.e);
                chk("latency",   cyc - e.go_cyc, e.lat);
            end
        end
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_op(input logic s, input logic [7:0] a, input logic [7:0] b, input exp_t e);
        @(negedge clk);
        b8.go = 1'b1; b8.sgn = s; b8.dividend = a; b8.divisor = b;
        @(posedge clk); #1;
        b8.go    = 1'b0;
        busy_cnt = 0;
        e.go_cyc = cyc;
        sb.push_back(e);
        wait_drain();
    endtask

    initial begin
        int         base, dc0, n;
        exp_t       e;
        logic       s;
        logic [7:0] a, b;

        rst = 1'b1;
        b8.go  = 1'b0; b8.sgn  = 1'b0; b8.dividend  = '0; b8.divisor  = '0;
        b4.go  = 1'b0; b4.sgn  = 1'b0; b4.dividend  = '0; b4.divisor  = '0;
        b16.go = 1'b0; b16.sgn = 1'b0; b16.dividend = '0; b16.divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_quotient",  b8.quotient,  0);
        chk("rst_remainder", b8.remainder, 0);
        chk("rst_error",     b8.error,     0);
        chk("rst_busy",      b8.busy,      0);
        chk("rst_done",      b8.done,      0);
        chk("rst_cs",        b8.cs,        IDLE);
        rst = 1'b0;

        run_op(1'b0, 8'd100, 8'd7, mk(8'd14, 8'd2, 1'b0));
        chk("busy_cycles_100_7", busy_cnt, 9);

        run_op(1'b0, 8'd55, 8'd0, mk(8'hFF, 8'd55, 1'b1));
        chk("busy_cycles_div0", busy_cnt, 1);
        run_op(1'b0, 8'd55, 8'd5, mk(8'd11, 8'd0, 1'b0));

        run_op(1'b1, 8'hF9, 8'h02, SIGNED_EN ? mk(8'hFD, 8'hFF, 1'b0) : mk(8'd124, 8'd1, 1'b0));
        run_op(1'b1, 8'h07, 8'hFE, SIGNED_EN ? mk(8'hFD, 8'h01, 1'b0) : mk(8'd0, 8'd7, 1'b0));
        run_op(1'b1, 8'h80, 8'hFF, SIGNED_EN ? mk(8'h80, 8'h00, 1'b0) : mk(8'd0, 8'h80, 1'b0));
        run_op(1'b0, 8'hF9, 8'h02, mk(8'd124, 8'd1, 1'b0));

        // go pulsed during CALC must be ignored; results hold meanwhile
        run_op(1'b0, 8'd200, 8'd3, mk(8'd66, 8'd2, 1'b0));
        dc0 = done_cnt;
        @(negedge clk);
        b8.go = 1'b1; b8.sgn = 1'b0; b8.dividend = 8'd100; b8.divisor = 8'd7;
        @(posedge clk); #1;
        b8.go = 1'b0;
        e = mk(8'd14, 8'd2, 1'b0);
        e.go_cyc = cyc;
        sb.push_back(e);
        repeat (3) @(negedge clk);
        chk("hold_quotient_calc", b8.quotient, 8'd66);
        chk("hold_error_calc",    b8.error,    0);
        chk("busy_in_calc",       b8.busy,     1);
        b8.go = 1'b1; b8.dividend = 8'd50; b8.divisor = 8'd5;
        @(negedge clk);
        b8.go = 1'b0;
        wait_drain();
        repeat (15) @(negedge clk);
        chk("single_done_go_in_calc", done_cnt - dc0, 1);

        // go held high: back-to-back operations every 10 cycles
        @(negedge clk);
        b8.go = 1'b1; b8.sgn = 1'b0; b8.dividend = 8'd55; b8.divisor = 8'd5;
        @(posedge clk); #1;
        base = cyc;
        e = mk(8'd11, 8'd0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            e.go_cyc = base + 10 * k;
            sb.push_back(e);
        end
        repeat (20) @(posedge clk);
        #1;
        b8.go = 1'b0;
        wait_drain();

        // reset in the fourth CALC cycle discards the operation
        @(negedge clk);
        b8.go = 1'b1; b8.dividend = 8'd100; b8.divisor = 8'd7;
        @(posedge clk); #1;
        b8.go = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_quotient",  b8.quotient,  0);
        chk("midrst_remainder", b8.remainder, 0);
        chk("midrst_error",     b8.error,     0);
        chk("midrst_busy",      b8.busy,      0);
        chk("midrst_done",      b8.done,      0);
        chk("midrst_cs",        b8.cs,        IDLE);
        rst = 1'b0;
        dc0 = done_cnt;
        repeat (15) @(negedge clk);
        chk("no_done_after_rst", done_cnt - dc0, 0);
        run_op(1'b0, 8'd100, 8'd7, mk(8'd14, 8'd2, 1'b0));

        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = 8'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            run_op(s, a, b, model(s, a, b));
        end

        @(negedge clk);
        b4.go = 1'b1; b4.dividend = 4'd15; b4.divisor = 4'd4;
        @(posedge clk); #1;
        base = cyc;
        b4.go = 1'b0;
        n = 0;
        while (!b4.done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("w4_latency",   cyc - base,   5);
        chk("w4_quotient",  b4.quotient,  4'd3);
        chk("w4_remainder", b4.remainder, 4'd3);

        @(negedge clk);
        b16.go = 1'b1; b16.dividend = 16'd65535; b16.divisor = 16'd255;
        @(posedge clk); #1;
        base = cyc;
        b16.go = 1'b0;
        n = 0;
        while (!b16.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("w16_latency",   cyc - base,    17);
        chk("w16_quotient",  b16.quotient,  16'd257);
        chk("w16_remainder", b16.remainder, 16'd0);
        chk("w16_error",     b16.error,     0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
